i2c_target_model: RTL

Parametrised, synthesizable I2C target that emulates the pH sensor on the system `sda`/`scl` bus. It replaces the ad-hoc `sda` driving in the system testbench with a real responder. It has a configurable 7-bit address, a configurable register-file depth and input glitch filtering. It supports auto-incrementing writes and reads, repeated START and a bench-side preload port. It also works as an on-board target for FPGA loopback tests.

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_line_filter.sv | 62 ++++++
 rtl/i2c_target_model.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types, constants and helpers for the I2C target model
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Protocol FSM states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } i2c_state_e;

    // R/W bit value that selects a read transfer
    localparam logic I2C_RW_READ = 1'b1;
    // SDA level that signals acknowledge
    localparam logic I2C_ACK     = 1'b0;

    // Next register pointer, wrapping from num_regs-1 back to 0
    function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                             input int unsigned num_regs);
        return (ptr + 32'd1) % num_regs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_line_filter
//  Description : 2-flop synchronizer plus stability filter for one bus line;
//                produces the filtered level and one-cycle edge flags
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;
    logic [3:0] w_cnt_inc;
    logic       w_settle;

    // r_cnt counts consecutive synchronized samples that differ from the
    // current filtered level; the level flips when that run reaches FILTER_LEN
    assign w_cnt_inc = r_cnt + 4'd1;
    assign w_settle  = (r_sync[1] != r_level) && (w_cnt_inc == 4'(FILTER_LEN));

    // Synchronize, then accept a new level only after a stable run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= 4'd0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], din};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= 4'd0;
            end else if (w_settle) begin
                r_cnt   <= 4'd0;
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
                r_fall  <= ~r_sync[1];
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/i2c_target_model.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_model
//  Description : Synthesizable I2C target with register file, auto-increment
//                pointer, repeated START support and a host preload port
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_model
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h63,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned FILTER_LEN  = 3,
    parameter int unsigned PTR_W       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic             preload_we,
    input  logic [PTR_W-1:0] preload_addr,
    input  logic [7:0]       preload_data,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (clk),
        .rst   (rst),
        .din   (scl_i),
        .level (w_scl_lvl),
        .rise  (w_scl_rise),
        .fall  (w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (clk),
        .rst   (rst),
        .din   (sda_i),
        .level (w_sda_lvl),
        .rise  (w_sda_rise),
        .fall  (w_sda_fall)
    );

    i2c_state_e       r_state, w_state_nxt;
    logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic             r_sda_oe, w_sda_oe_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_bus_we;
    logic [7:0]       r_regs [NUM_REGS];
    logic             r_wr_strobe;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;

    logic             w_start;
    logic             w_stop;
    logic [7:0]       w_byte;
    logic [7:0]       w_rd_byte;
    logic [PTR_W-1:0] w_ptr_inc;

    // Bus conditions: SDA edges while SCL is high
    assign w_start   = w_sda_fall & w_scl_lvl;
    assign w_stop    = w_sda_rise & w_scl_lvl;
    // Byte as it stands once the current bit is shifted in
    assign w_byte    = {r_shift[6:0], w_sda_lvl};
    assign w_rd_byte = r_regs[r_ptr];
    assign w_ptr_inc = PTR_W'(ptr_wrap(32'(r_ptr), NUM_REGS));

    // FSM state register and protocol datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'd0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state and datapath decode; START/STOP override every state.
    // Byte states enter their ACK state on the SCL fall that ends bit 8,
    // and ACK states leave on the following SCL fall, so sda_oe only ever
    // moves on SCL falls outside of START/STOP.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_bus_we      = 1'b0;

        if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            if (r_state == ST_ADDR) begin
                                if (w_byte[7:1] == TARGET_ADDR) begin
                                    w_busy_nxt = 1'b1;
                                end else begin
                                    w_state_nxt   = ST_IDLE;
                                    w_bit_cnt_nxt = 4'd0;
                                end
                            end else if (r_state == ST_PTR) begin
                                w_ptr_nxt = w_byte[PTR_W-1:0];
                            end else begin
                                w_bus_we  = 1'b1;
                                w_ptr_nxt = w_ptr_inc;
                            end
                        end
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        w_bit_cnt_nxt = 4'd0;
                        w_sda_oe_nxt  = (I2C_ACK == 1'b0);
                        case (r_state)
                            ST_ADDR: w_state_nxt = ST_ADDR_ACK;
                            ST_PTR:  w_state_nxt = ST_PTR_ACK;
                            default: w_state_nxt = ST_WDATA_ACK;
                        endcase
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_shift[0] == I2C_RW_READ) begin
                            w_state_nxt  = ST_RDATA;
                            w_sda_oe_nxt = ~w_rd_byte[7];
                            w_shift_nxt  = {w_rd_byte[6:0], 1'b0};
                        end else begin
                            w_state_nxt  = ST_PTR;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt   = ST_WDATA;
                        w_bit_cnt_nxt = 4'd0;
                        w_sda_oe_nxt  = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_state_nxt   = ST_RDATA_ACK;
                            w_bit_cnt_nxt = 4'd0;
                            w_sda_oe_nxt  = 1'b0;
                        end else begin
                            w_sda_oe_nxt = ~r_shift[7];
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    // bit_cnt==1 records that the controller acknowledged
                    if (w_scl_rise) begin
                        if (w_sda_lvl == I2C_ACK) begin
                            w_ptr_nxt     = w_ptr_inc;
                            w_bit_cnt_nxt = 4'd1;
                        end else begin
                            w_state_nxt   = ST_IDLE;
                            w_bit_cnt_nxt = 4'd0;
                            w_sda_oe_nxt  = 1'b0;
                        end
                    end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
                        w_state_nxt   = ST_RDATA;
                        w_bit_cnt_nxt = 4'd0;
                        w_sda_oe_nxt  = ~w_rd_byte[7];
                        w_shift_nxt   = {w_rd_byte[6:0], 1'b0};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register file: host preload first, bus write last so the bus wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= 8'd0;
            end
        end else begin
            if (preload_we) begin
                r_regs[preload_addr] <= preload_data;
            end
            if (w_bus_we) begin
                r_regs[r_ptr] <= w_byte;
            end
        end
    end

    // Write notification: strobe one cycle after the 8th data bit, values held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'd0;
        end else begin
            r_wr_strobe <= w_bus_we;
            if (w_bus_we) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte;
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign busy      = r_busy;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

endmodule
`default_nettype wire
